// File: rtl/programmable_processor.sv
// Multi-cycle 16-bit CPU: instruction ROM, data RAM, 16x16 register file, ALU and a
// two-process control FSM. PC, IR, FSM state and ALU operands/result are exported for debug.
module programmable_processor #(
    parameter string PROG_FILE = "program.hex",
    parameter string DATA_FILE = "data.hex"
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] IR_Out,
    output logic [6:0]  PC_Out,
    output logic [3:0]  State,
    output logic [3:0]  NextState,
    output logic [15:0] ALU_A,
    output logic [15:0] ALU_B,
    output logic [15:0] ALU_Out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [15:0] rom  [0:127];
    logic [15:0] ram  [0:255];
    logic [15:0] regs [0:15];
    logic [15:0] ram_rdata;
    logic [2:0]  ALU_s0;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [3:0]  opcode;

    assign opcode    = ir[15:12];
    assign ALU_A     = regs[ir[11:8]];
    assign ALU_B     = regs[ir[7:4]];
    assign rf_wdata  = (state == S_LOADB) ? ram_rdata : ALU_Out;
    assign IR_Out    = ir;
    assign PC_Out    = pc;
    assign State     = state;
    assign NextState = next_state;

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unknown opcodes decode as NOOP.
    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'd1:    next_state = S_STORE;
                    4'd2:    next_state = S_LOADA;
                    4'd3:    next_state = S_ADD;
                    4'd4:    next_state = S_SUB;
                    4'd5:    next_state = S_HALT;
                    default: next_state = S_NOOP;
                endcase
            end
            S_LOADA:  next_state = S_LOADB;
            S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        ALU_s0 = 3'b000;
        D_Addr = 8'h00;
        D_Wr   = 1'b0;
        rf_we  = 1'b0;
        case (state)
            S_LOADA: D_Addr = ir[11:4];
            S_LOADB: begin
                D_Addr = ir[11:4];
                rf_we  = 1'b1;
            end
            S_STORE: begin
                D_Addr = ir[7:0];
                D_Wr   = 1'b1;
            end
            S_ADD: begin
                ALU_s0 = 3'b001;
                rf_we  = 1'b1;
            end
            S_SUB: begin
                ALU_s0 = 3'b010;
                rf_we  = 1'b1;
            end
            default: ALU_s0 = 3'b000;
        endcase
    end

    // ALU, arithmetic modulo 2^16 with no flags.
    always_comb begin
        ALU_Out = 16'h0000;
        case (ALU_s0)
            3'b000:  ALU_Out = 16'h0000;
            3'b001:  ALU_Out = ALU_A + ALU_B;
            3'b010:  ALU_Out = ALU_A - ALU_B;
            3'b011:  ALU_Out = ALU_A;
            3'b100:  ALU_Out = ALU_B;
            3'b101:  ALU_Out = ALU_A & ALU_B;
            3'b110:  ALU_Out = ALU_A | ALU_B;
            3'b111:  ALU_Out = ALU_A + 16'd1;
            default: ALU_Out = 16'h0000;
        endcase
    end

    // Program counter and instruction register; PC wraps naturally at 7 bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc <= 7'd0;
            ir <= 16'h0000;
        end else if (state == S_FETCH) begin
            ir <= rom[pc];
            pc <= pc + 7'd1;
        end else begin
            pc <= pc;
            ir <= ir;
        end
    end

    // Register file write port.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (rf_we) begin
            regs[ir[3:0]] <= rf_wdata;
        end else begin
            regs[ir[3:0]] <= regs[ir[3:0]];
        end
    end

    // Data RAM: synchronous write, registered read; contents survive reset.
    always_ff @(posedge Clk) begin
        if (D_Wr) begin
            ram[D_Addr] <= ALU_A;
        end
        ram_rdata <= ram[D_Addr];
    end

endmodule

// File: tb/tb_programmable_processor.sv
// Bench for programmable_processor: instruction-level reference model checked every cycle,
// plus directed programs with hand-computed literal expectations.
module tb_programmable_processor;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IR_Out, ALU_A, ALU_B, ALU_Out;
    logic [6:0]  PC_Out;
    logic [3:0]  State, NextState;

    int total = 0;
    int bad   = 0;

    programmable_processor #(.PROG_FILE(""), .DATA_FILE("")) dut (
        .Clk(Clk), .Reset(Reset), .IR_Out(IR_Out), .PC_Out(PC_Out), .State(State),
        .NextState(NextState), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Out(ALU_Out)
    );

    always #5 Clk = ~Clk;

    // Architectural model: memories, registers, PC/IR, and position within the instruction.
    logic [15:0] m_rom  [0:127];
    logic [15:0] m_ram  [0:255];
    logic [15:0] m_regs [0:15];
    logic [6:0]  m_pc;
    logic [15:0] m_ir;
    int          m_mode;   // 0 before first fetch, 1 running, 2 halted
    int          m_step;   // cycle index inside the current instruction, 0 = fetch

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exec_state(input logic [3:0] op);
        case (op)
            4'd1:    return 6;
            4'd2:    return 4;
            4'd3:    return 7;
            4'd4:    return 8;
            4'd5:    return 9;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_pc   = 7'd0;
        m_ir   = 16'h0000;
        m_mode = 0;
        m_step = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    endtask

    task automatic model_advance();
        logic [3:0]  op;
        logic [15:0] a, b;
        op = m_ir[15:12];
        a  = m_regs[m_ir[11:8]];
        b  = m_regs[m_ir[7:4]];
        if (m_mode == 0) begin
            m_mode = 1;
            m_step = 0;
        end else if (m_mode == 1) begin
            case (m_step)
                0: begin
                    m_ir   = m_rom[m_pc];
                    m_pc   = m_pc + 7'd1;
                    m_step = 1;
                end
                1: m_step = 2;
                2: begin
                    m_step = 0;
                    case (op)
                        4'd1: m_ram[m_ir[7:0]] = a;
                        4'd2: m_step = 3;
                        4'd3: m_regs[m_ir[3:0]] = a + b;
                        4'd4: m_regs[m_ir[3:0]] = a - b;
                        4'd5: m_mode = 2;
                        default: ;
                    endcase
                end
                default: begin
                    m_regs[m_ir[3:0]] = m_ram[m_ir[11:4]];
                    m_step = 0;
                end
            endcase
        end
    endtask

    task automatic check_cycle();
        logic [3:0]  op;
        logic [15:0] a, b, eout;
        logic [2:0]  es0;
        logic [7:0]  eaddr;
        logic        ewr;
        int          es, ens;
        op = m_ir[15:12];
        a  = m_regs[m_ir[11:8]];
        b  = m_regs[m_ir[7:4]];
        eout = 16'h0000; es0 = 3'b000; eaddr = 8'h00; ewr = 1'b0;
        if (m_mode == 0) begin
            es = 0; ens = 1;
        end else if (m_mode == 2) begin
            es = 9; ens = 9;
        end else begin
            case (m_step)
                0: begin es = 1; ens = 2; end
                1: begin es = 2; ens = exec_state(op); end
                2: begin
                    es  = exec_state(op);
                    ens = (op == 4'd2) ? 5 : ((op == 4'd5) ? 9 : 1);
                    case (op)
                        4'd1: begin eaddr = m_ir[7:0]; ewr = 1'b1; end
                        4'd2: eaddr = m_ir[11:4];
                        4'd3: begin eout = a + b; es0 = 3'b001; end
                        4'd4: begin eout = a - b; es0 = 3'b010; end
                        default: ;
                    endcase
                end
                default: begin es = 5; ens = 1; eaddr = m_ir[11:4]; end
            endcase
        end
        chk("state", State, es);
        chk("next_state", NextState, ens);
        chk("pc", PC_Out, m_pc);
        chk("ir", IR_Out, m_ir);
        chk("alu_a", ALU_A, a);
        chk("alu_b", ALU_B, b);
        chk("alu_out", ALU_Out, eout);
        chk("alu_s0", dut.ALU_s0, es0);
        chk("d_addr", dut.D_Addr, eaddr);
        chk("d_wr", dut.D_Wr, ewr);
        for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), dut.regs[i], m_regs[i]);
    endtask

    // Per-cycle comparison against the model; the model steps on each rising edge.
    initial begin : compare_proc
        forever begin
            @(negedge Clk);
            if (!Reset) model_reset();
            check_cycle();
            @(posedge Clk);
            if (!Reset) model_reset();
            else model_advance();
        end
    end

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (State !== s && n < budget);
        chk($sformatf("wait_state_%0d", s), State, s);
    endtask

    task automatic load_rom(input int idx, input logic [15:0] word);
        m_rom[idx]   = word;
        dut.rom[idx] = word;
    endtask

    task automatic load_ram(input int idx, input logic [15:0] word);
        m_ram[idx]   = word;
        dut.ram[idx] = word;
    endtask

    initial begin : stimulus
        int n;
        for (int i = 0; i < 128; i++) load_rom(i, 16'h0000);
        for (int i = 0; i < 256; i++) load_ram(i, 16'hA500 ^ 16'(i));
        load_rom(0, 16'h21B0);
        load_rom(1, 16'h21C1);
        load_rom(2, 16'h3012);
        load_rom(3, 16'h121D);
        load_rom(4, 16'h5000);
        load_ram(8'h1B, 16'h0005);
        load_ram(8'h1C, 16'h0003);
        model_reset();
        #1 Reset = 1'b0;

        @(negedge Clk);
        chk("rst_state", State, 4'd0);
        chk("rst_pc", PC_Out, 7'h00);
        chk("rst_ir", IR_Out, 16'h0000);
        chk("rst_next", NextState, 4'd1);
        @(posedge Clk);
        #2 Reset = 1'b1;

        // Program A: LOAD, LOAD, ADD, STORE, HALT.
        wait_state(4'd5, 20);
        @(negedge Clk);
        chk("load_r0", dut.regs[0], 16'h0005);
        chk("load_pc", PC_Out, 7'h01);
        wait_state(4'd7, 20);
        chk("add_a", ALU_A, 16'h0005);
        chk("add_b", ALU_B, 16'h0003);
        chk("add_out", ALU_Out, 16'h0008);
        wait_state(4'd6, 20);
        chk("store_wr", dut.D_Wr, 1'b1);
        chk("store_addr", dut.D_Addr, 8'h1D);
        @(negedge Clk);
        chk("store_ram", dut.ram[8'h1D], 16'h0008);
        chk("add_r2", dut.regs[2], 16'h0008);
        wait_state(4'd9, 20);
        chk("halt_ir", IR_Out, 16'h5000);
        repeat (5) @(negedge Clk);
        chk("halt_state", State, 4'd9);
        chk("halt_pc", PC_Out, 7'h05);

        // Program B: SUB wrap, unknown opcode, ADD, STORE, then run through PC wrap.
        @(posedge Clk);
        #2 Reset = 1'b0;
        load_rom(0, 16'h2010);
        load_rom(1, 16'h2021);
        load_rom(2, 16'h4102);
        load_rom(3, 16'hF123);
        load_rom(4, 16'h3223);
        load_rom(5, 16'h1240);
        load_ram(8'h01, 16'h0005);
        load_ram(8'h02, 16'h0003);
        @(negedge Clk);
        chk("rst2_r2", dut.regs[2], 16'h0000);
        chk("rst2_ram_kept", dut.ram[8'h1D], 16'h0008);
        @(posedge Clk);
        #2 Reset = 1'b1;
        wait_state(4'd8, 40);
        chk("sub_out", ALU_Out, 16'hFFFE);
        @(negedge Clk);
        chk("sub_r2", dut.regs[2], 16'hFFFE);
        wait_state(4'd3, 20);
        chk("bad_op_ir", IR_Out, 16'hF123);
        chk("bad_op_r3", dut.regs[3], 16'h0000);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(State === 4'd1 && PC_Out === 7'h00) && n < 600);
        chk("wrap_pc", PC_Out, 7'h00);
        chk("wrap_ir", IR_Out, 16'h0000);
        chk("store_b_ram", dut.ram[8'h40], 16'hFFFE);
        chk("add_b_r3", dut.regs[3], 16'hFFFC);

        // Abort a STORE with reset: the write must not happen.
        load_ram(8'h40, 16'h1234);
        wait_state(4'd6, 40);
        #2 Reset = 1'b0;
        @(negedge Clk);
        chk("abort_state", State, 4'd0);
        chk("abort_ram", dut.ram[8'h40], 16'h1234);
        @(posedge Clk);
        #2 Reset = 1'b1;
        repeat (30) @(negedge Clk);
        for (int i = 0; i < 256; i++) chk($sformatf("ram%0h", i), dut.ram[i], m_ram[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
